// File: rtl/vga_pkg.sv
// Shared raster timing defaults (640x480@60) and helpers for the VGA scan-out block.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
      logic frame_start;
   } vga_sync_t;

   localparam vga_sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, frame_start: 1'b0};

   function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous pixel FIFO with a combinational head; a push while full only lands if a pop frees a slot.
module vga_pix_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign level    = count;

endmodule

// File: rtl/vga_scan_out.sv
// Buffers the upstream pixel stream and drains it under a free-running VGA raster generator.
module vga_scan_out
   import vga_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [WIDTH-1:0]              pix_in,
   input  logic                          pix_valid_in,
   input  logic                          enable_in,
   input  logic                          clr_err_in,
   output logic                          hsync_out,
   output logic                          vsync_out,
   output logic                          de_out,
   output logic [WIDTH-1:0]              rgb_out,
   output logic                          frame_start_out,
   output logic [$clog2(FIFO_DEPTH):0]   level_out,
   output logic                          overflow_out,
   output logic                          underflow_out
);

   localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int LW      = $clog2(FIFO_DEPTH) + 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0]    h;
   logic [VW-1:0]    v;
   logic             en_q;
   logic             run;
   logic             visible;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_head;
   logic [LW-1:0]    fifo_level;
   vga_sync_t        sync_d;
   vga_sync_t        sync_q;

   vga_pix_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (pix_valid_in),
      .push_data (pix_in),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // The raster only runs once enable has been seen for a full cycle, so a
   // fresh enable spends one cycle parked at (0,0) before that pixel is emitted.
   assign run     = enable_in & en_q;
   assign visible = (h < H_VIS) && (v < V_VIS);
   assign pop     = run & visible;

   always_comb begin
      sync_d = SYNC_IDLE;
      if (run) begin
         sync_d.hsync       = !((h >= HS_BEG) && (h < HS_END));
         sync_d.vsync       = !((v >= VS_BEG) && (v < VS_END));
         sync_d.de          = visible;
         sync_d.frame_start = (h == '0) && (v == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         en_q          <= 1'b0;
         h             <= '0;
         v             <= '0;
         sync_q        <= SYNC_IDLE;
         rgb_out       <= '0;
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
      end else begin
         en_q <= enable_in;
         if (!enable_in) begin
            h <= '0;
            v <= '0;
         end else if (en_q) begin
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
               h <= h + HW'(1);
            end
         end
         sync_q  <= sync_d;
         rgb_out <= (pop && !fifo_empty) ? fifo_head : '0;
         // A set in the same cycle as a clear wins.
         overflow_out  <= (overflow_out & ~clr_err_in) | (pix_valid_in & fifo_full & ~pop);
         underflow_out <= (underflow_out & ~clr_err_in) | (pop & fifo_empty);
      end
   end

   assign hsync_out       = sync_q.hsync;
   assign vsync_out       = sync_q.vsync;
   assign de_out          = sync_q.de;
   assign frame_start_out = sync_q.frame_start;
   assign level_out       = fifo_level;

endmodule

// File: tb/tb_vga_scan_out.sv
// Self-checking bench for vga_scan_out on a tiny 8x6 raster with a 4-deep buffer.
module tb_vga_scan_out;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] pix_in;
   logic       pix_valid_in;
   logic       enable_in;
   logic       clr_err_in;
   logic       hsync_out, vsync_out, de_out, frame_start_out;
   logic [3:0] rgb_out;
   logic [2:0] level_out;
   logic       overflow_out, underflow_out;

   vga_scan_out #(
      .WIDTH (4), .FIFO_DEPTH (DEPTH),
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .clk (clk), .resetn (resetn), .pix_in (pix_in), .pix_valid_in (pix_valid_in),
      .enable_in (enable_in), .clr_err_in (clr_err_in),
      .hsync_out (hsync_out), .vsync_out (vsync_out), .de_out (de_out), .rgb_out (rgb_out),
      .frame_start_out (frame_start_out), .level_out (level_out),
      .overflow_out (overflow_out), .underflow_out (underflow_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: raster position as a plain cycle count since frame start.
   int         m_pos;
   bit         m_en_prev;
   logic [3:0] m_q[$];
   bit         e_hs, e_vs, e_de, e_fs, e_of, e_uf;
   logic [3:0] e_rgb;

   task automatic model_reset();
      m_pos = 0; m_en_prev = 0; m_q.delete();
      e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_of = 0; e_uf = 0; e_rgb = 0;
   endtask

   task automatic model_step();
      bit act, vis;
      int hh, vv;
      act = enable_in && m_en_prev;
      vis = 0;
      if (act) begin
         hh   = m_pos % HT;
         vv   = (m_pos / HT) % VT;
         vis  = (hh < HA) && (vv < VA);
         e_hs = !(hh >= HA + HF && hh < HA + HF + HS);
         e_vs = !(vv >= VA + VF && vv < VA + VF + VS);
         e_de = vis;
         e_fs = (m_pos % (HT * VT)) == 0;
         m_pos++;
      end else begin
         e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0;
         m_pos = 0;
      end
      m_en_prev = enable_in;
      if (clr_err_in) begin e_of = 0; e_uf = 0; end
      e_rgb = 0;
      if (vis) begin
         if (m_q.size() > 0) e_rgb = m_q.pop_front();
         else e_uf = 1;
      end
      if (pix_valid_in) begin
         if (m_q.size() < DEPTH) m_q.push_back(pix_in);
         else e_of = 1;
      end
   endtask

   task automatic compare_all();
      chk("hsync", hsync_out, e_hs);
      chk("vsync", vsync_out, e_vs);
      chk("de", de_out, e_de);
      chk("rgb", rgb_out, e_rgb);
      chk("frame_start", frame_start_out, e_fs);
      chk("level", level_out, m_q.size());
      chk("overflow", overflow_out, e_of);
      chk("underflow", underflow_out, e_uf);
   endtask

   // Entered and left at a negedge.
   task automatic cyc(input bit vld, input logic [3:0] d, input bit en, input bit clr);
      pix_valid_in = vld; pix_in = d; enable_in = en; clr_err_in = clr;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      resetn = 0; pix_valid_in = 0; pix_in = 0; enable_in = 0; clr_err_in = 0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      model_reset();
      chk("rst_hsync", hsync_out, 1);
      chk("rst_vsync", vsync_out, 1);
      chk("rst_de", de_out, 0);
      chk("rst_rgb", rgb_out, 0);
      chk("rst_fs", frame_start_out, 0);
      chk("rst_level", level_out, 0);
      chk("rst_ovf", overflow_out, 0);
      chk("rst_udf", underflow_out, 0);
      resetn = 1;
   endtask

   initial begin
      int nxt, de_cnt, fs_cnt, vs_cnt, hs_cnt, first_de, first_hs;
      logic [3:0] seen[$];
      bit vld, en;

      resetn = 0; pix_valid_in = 0; pix_in = 0; enable_in = 0; clr_err_in = 0;
      @(negedge clk);
      do_reset();

      // Raster shape over one full frame, refilling as the buffer drains.
      nxt = 1;
      for (int i = 0; i < 4; i++) begin cyc(1, 4'(nxt), 0, 0); nxt++; end
      de_cnt = 0; fs_cnt = 0; vs_cnt = 0; hs_cnt = 0; first_de = -1; first_hs = -1;
      seen.delete();
      for (int k = 0; k <= HT * VT; k++) begin
         vld = (nxt <= 12) && (m_q.size() < DEPTH);
         cyc(vld, vld ? 4'(nxt) : 4'd0, 1, 0);
         if (vld) nxt++;
         if (de_out) begin
            de_cnt++; seen.push_back(rgb_out);
            if (first_de < 0) first_de = k;
         end
         if (!hsync_out) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = k;
         end
         if (!vsync_out) vs_cnt++;
         if (frame_start_out) fs_cnt++;
      end
      chk("ras_de_cnt", de_cnt, 12);
      chk("ras_fs_cnt", fs_cnt, 1);
      chk("ras_vs_cnt", vs_cnt, 8);
      chk("ras_hs_cnt", hs_cnt, 12);
      chk("ras_hs_offset", first_hs - first_de, 5);
      chk("ras_udf", underflow_out, 0);
      for (int i = 0; i < seen.size() && i < 12; i++) chk("ras_pix", seen[i], i + 1);
      cyc(0, 0, 0, 0);

      // Underflow with an empty buffer, then clear.
      do_reset();
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      chk("udf_de", de_out, 1);
      chk("udf_rgb", rgb_out, 0);
      chk("udf_flag", underflow_out, 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      chk("udf_hold", underflow_out, 1);
      cyc(0, 0, 0, 1);
      chk("udf_clr", underflow_out, 0);

      // Overflow: five pushes while idle.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 4'(10 + i), 0, 0);
      chk("ovf_level", level_out, 4);
      chk("ovf_flag", overflow_out, 1);
      seen.delete();
      for (int k = 0; k < 6; k++) begin
         cyc(0, 0, 1, 0);
         if (de_out) seen.push_back(rgb_out);
      end
      chk("ovf_npop", seen.size(), 4);
      for (int i = 0; i < seen.size() && i < 4; i++) chk("ovf_pix", seen[i], 10 + i);
      cyc(0, 0, 0, 0);

      // Push and pop together while full.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 4'(i + 1), 0, 0);
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(1, 4'(5 + i), 1, 0);
      chk("fpp_level", level_out, 4);
      chk("fpp_ovf", overflow_out, 0);
      cyc(0, 0, 0, 0);

      // Enable drop mid-line and re-enable.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 4'(i + 3), 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      chk("drop_de", de_out, 0);
      chk("drop_hsync", hsync_out, 1);
      chk("drop_rgb", rgb_out, 0);
      cyc(0, 0, 1, 0);
      chk("reen_fs_wait", frame_start_out, 0);
      cyc(0, 0, 1, 0);
      chk("reen_fs", frame_start_out, 1);
      chk("reen_de", de_out, 1);

      // Randomized traffic with occasional enable toggles, clears and resets.
      en = 1;
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 99) < 3) en = !en;
         if ($urandom_range(0, 999) < 3) do_reset();
         else cyc($urandom_range(0, 99) < 55, 4'($urandom), en, $urandom_range(0, 99) < 5);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

- Downstream consumer of the pixel-select stage.
- Accepts the registered pixel stream (`result_out`/`valid_out`) into a small synchronous FIFO.
- Drains the FIFO under a free-running VGA raster timing generator, producing `hsync`/`vsync`/data-enable and the pixel value.
- Single clock domain: `clk` is the pixel clock. Also reports buffer level and sticky over/underflow errors to the control logic.

## Interface
- `WIDTH`, 4, pixel width (matches upstream result width)
- `FIFO_DEPTH`, 16, pixel buffer entries (power of two, ≥2)
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48; horizontal front porch, sync, back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33; vertical front porch, sync, back porch (lines)
- `clk`  in  1  pixel clock
- `resetn`  in  1  reset: synchronous, active-low
- `pix_in`  in  WIDTH  pixel from upstream stage
- `pix_valid_in`  in  1  `pix_in` valid this cycle (no backpressure exists upstream)
- `enable_in`  in  1  raster run enable
- `clr_err_in`  in  1  clears sticky error flags
- `hsync_out`  out  1  horizontal sync, active-low
- `vsync_out`  out  1  vertical sync, active-low
- `de_out`  out  1  data enable (visible region)
- `rgb_out`  out  WIDTH  pixel value; 0 when `de_out`=0
- `frame_start_out`  out  1  one-cycle pulse aligned with pixel (0,0)
- `level_out`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- `overflow_out`  out  1  sticky: push while full was dropped
- `underflow_out`  out  1  sticky: pop while empty

## Operation

**Totals**
- `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP`.
- `V_TOTAL` = `V_ACTIVE`+`V_FP`+`V_SYNC`+`V_BP`.

**Counters**
- `h` counts 0..`H_TOTAL`-1 and wraps to 0, advancing `v`.
- `v` counts 0..`V_TOTAL`-1 and wraps to 0.
- Both advance only while `enable_in`=1.
- `enable_in`=0 forces `h`=`v`=0 and holds them there. Re-enable starts a fresh frame at (0,0).

**Region decode, per counter state**
- visible = `h`<`H_ACTIVE` && `v`<`V_ACTIVE`.
- hsync asserted (low) for `H_ACTIVE`+`H_FP` ≤ `h` < `H_ACTIVE`+`H_FP`+`H_SYNC`.
- vsync asserted (low) for `V_ACTIVE`+`V_FP` ≤ `v` < `V_ACTIVE`+`V_FP`+`V_SYNC`. The whole line is affected, independent of `h`.

**FIFO**
- Push when `pix_valid_in`=1. Pop when visible and `enable_in`=1.
- Push while full with no pop: data dropped, `overflow_out` set.
- Push and pop together while full: both succeed, level unchanged.
- Pop while empty: `rgb_out`=0 for that pixel, `underflow_out` set. A simultaneous push is stored, with no fall-through.

**Error flags**
- Flags stay set until `clr_err_in`=1 or reset.
- A set and a clear in the same cycle resolve as set.

**Idle outputs** (`enable_in`=0): `hsync_out`=1, `vsync_out`=1, `de_out`=0, `rgb_out`=0. The FIFO keeps accepting pushes.

## Timing
- All outputs are registered.
- `hsync_out`, `vsync_out`, `de_out`, `rgb_out` and `frame_start_out` reflect counter state (h,v) one cycle later.
- `rgb_out` is the popped FIFO head in that same cycle.
- `enable_in` 0→1 at edge N: counters are at (0,0) during cycle N+1, and `frame_start_out`=1 and first `de_out`=1 appear in cycle N+2.
- `enable_in` 1→0: outputs go idle on the next cycle.
- `level_out` updates the cycle after a push or pop.
- Reset values:
  - `hsync_out`=1, `vsync_out`=1, `de_out`=0, `rgb_out`=0, `frame_start_out`=0
  - `level_out`=0, `overflow_out`=0, `underflow_out`=0
  - FIFO pointers and counters = 0
- Reset mid-frame empties the FIFO and restarts the raster only once `enable_in` is high.

## Structure
- Shared package `vga_pkg`: default timing constants (640x480@60 values) and a function computing `H_TOTAL`/`V_TOTAL`.
- Sub-module `vga_pix_fifo`: synchronous FIFO with `WIDTH`/`DEPTH` parameters and push, pop, full, empty and level ports. It has no error logic; `vga_scan_out` owns the sticky flags.
- Timing counters, decode and output registers live in `vga_scan_out`.

## Test plan
Small parameters for all scenarios: `H_ACTIVE`=4, `H_FP`=1, `H_SYNC`=2, `H_BP`=1, `V_ACTIVE`=3, `V_FP`=1, `V_SYNC`=1, `V_BP`=1, `FIFO_DEPTH`=4.
- **Reset:** hold `resetn`=0 for 3 cycles → all outputs at reset values; `level_out`=0.
- **Raster shape:** preload 12 pixels 1..12, enable for 48 cycles →
  - each line shows `de_out` high for 4 cycles with `rgb_out` 1,2,3,4 / 5..8 / 9..12, then `hsync_out` low for 2 cycles starting 5 cycles after the first `de_out` of the line;
  - `vsync_out` is low for all of line 4 (8 cycles);
  - `frame_start_out` pulses once.
  - Refill during the frame, since the 4-deep FIFO cannot hold 12 pixels.
- **Underflow:** enable with an empty FIFO → `rgb_out`=0 while `de_out`=1, and `underflow_out`=1 from the first visible cycle onward. `clr_err_in` pulse → flag drops next cycle.
- **Overflow:** push 5 pixels A..E with `enable_in`=0 → `level_out`=4, `overflow_out`=1, and the first 4 popped values are A..D.
- **Full push+pop:** FIFO full and `pix_valid_in`=1 on a visible cycle → `level_out` stays 4 and `overflow_out` stays 0.
- **Enable drop mid-line:** deassert at h=2 → idle outputs next cycle; re-enable → `frame_start_out` two cycles later at (0,0).
